// File: rtl/onecold_encoder.sv
// onecold_encoder: two-stage valid/ready pipeline that converts an 8-bit
// one-cold code (upper bits all ones) into its zero-extended bit index.
// Illegal words produce all ones with err set, and a saturating counter
// tracks how many illegal results reached the output stage.
module onecold_encoder #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr_err,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] data_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] data_out,
   output logic             err,
   output logic [15:0]      err_cnt
);

   // Encode one word: returns {err, data}. Legal means exactly one zero in
   // the low byte and every bit above the low byte set.
   function automatic logic [WIDTH:0] encode_code(input logic [WIDTH-1:0] code);
      logic [3:0]       zeros;
      logic [2:0]       idx;
      logic [WIDTH-1:0] upper_mask;
      logic             upper_ok;
      zeros      = 4'd0;
      idx        = 3'd0;
      upper_mask = {WIDTH{1'b1}} << 4'd8;
      upper_ok   = ((code & upper_mask) == upper_mask);
      for (int i = 0; i < 8; i++) begin
         if (code[i] == 1'b0) begin
            zeros = zeros + 4'd1;
            idx   = i[2:0];
         end else begin
            zeros = zeros;
         end
      end
      if ((zeros == 4'd1) && upper_ok) begin
         encode_code = {1'b0, {(WIDTH-3){1'b0}}, idx};
      end else begin
         encode_code = {1'b1, {WIDTH{1'b1}}};
      end
   endfunction

   logic             s1_valid_r;
   logic [WIDTH-1:0] s1_data_r;
   logic             s2_valid_r;
   logic [WIDTH-1:0] s2_data_r;
   logic             s2_err_r;
   logic [15:0]      err_cnt_r;

   logic             s2_load_s;
   logic             s2_drain_s;
   logic             accept_s;
   logic             in_ready_s;
   logic [WIDTH:0]   enc_s;

   // Handshake decisions and encoding of the word waiting in S1.
   always_comb begin
      s2_load_s  = 1'b0;
      s2_drain_s = 1'b0;
      in_ready_s = 1'b0;
      accept_s   = 1'b0;
      enc_s      = encode_code(s1_data_r);
      s2_load_s  = s1_valid_r && (!s2_valid_r || out_ready);
      s2_drain_s = s2_valid_r && out_ready;
      // in_ready is forced low while reset is held.
      if (rst) begin
         in_ready_s = en && (!s1_valid_r || s2_load_s);
      end else begin
         in_ready_s = 1'b0;
      end
      accept_s = in_valid && in_ready_s;
   end

   // Stage 1: capture the raw input word on an accepted transfer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid_r <= 1'b0;
         s1_data_r  <= {WIDTH{1'b0}};
      end else if (accept_s) begin
         s1_valid_r <= 1'b1;
         s1_data_r  <= data_in;
      end else if (s2_load_s) begin
         s1_valid_r <= 1'b0;
      end
   end

   // Stage 2: hold the encoded result; data/err are zero while empty.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s2_valid_r <= 1'b0;
         s2_data_r  <= {WIDTH{1'b0}};
         s2_err_r   <= 1'b0;
      end else if (s2_load_s) begin
         s2_valid_r <= 1'b1;
         s2_data_r  <= enc_s[WIDTH-1:0];
         s2_err_r   <= enc_s[WIDTH];
      end else if (s2_drain_s) begin
         s2_valid_r <= 1'b0;
         s2_data_r  <= {WIDTH{1'b0}};
         s2_err_r   <= 1'b0;
      end
   end

   // Saturating illegal-code counter; a clear beats a same-edge increment.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_cnt_r <= 16'h0000;
      end else if (clr_err) begin
         err_cnt_r <= 16'h0000;
      end else if (s2_load_s && enc_s[WIDTH] && (err_cnt_r != 16'hFFFF)) begin
         err_cnt_r <= err_cnt_r + 16'h0001;
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = s2_valid_r;
   assign data_out  = s2_data_r;
   assign err       = s2_err_r;
   assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_onecold_encoder.sv
// Directed bench for onecold_encoder: table-driven sweep of legal and
// illegal codes, then hand-written backpressure, enable, counter
// saturation/clear and mid-flight reset sequences.
module tb_onecold_encoder;

   localparam int WIDTH = 32;

   logic             clk;
   logic             rst;
   logic             en;
   logic             clr_err;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] data_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] data_out;
   logic             err;
   logic [15:0]      err_cnt;

   int checks;
   int failures;

   typedef struct {
      logic [31:0] din;
      logic [31:0] dout;
      logic        derr;
   } vec_t;

   vec_t vecs [12];

   onecold_encoder #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .clr_err   (clr_err),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out),
      .err       (err),
      .err_cnt   (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst       = 1'b0;
      en        = 1'b1;
      clr_err   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      data_in   = 32'hFFFF_FFFF;

      vecs[0]  = '{32'hFFFF_FFFE, 32'd0, 1'b0};
      vecs[1]  = '{32'hFFFF_FFFD, 32'd1, 1'b0};
      vecs[2]  = '{32'hFFFF_FFFB, 32'd2, 1'b0};
      vecs[3]  = '{32'hFFFF_FFF7, 32'd3, 1'b0};
      vecs[4]  = '{32'hFFFF_FFEF, 32'd4, 1'b0};
      vecs[5]  = '{32'hFFFF_FFDF, 32'd5, 1'b0};
      vecs[6]  = '{32'hFFFF_FFBF, 32'd6, 1'b0};
      vecs[7]  = '{32'hFFFF_FF7F, 32'd7, 1'b0};
      vecs[8]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1};
      vecs[9]  = '{32'hFFFF_FFFC, 32'hFFFF_FFFF, 1'b1};
      vecs[10] = '{32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b1};
      vecs[11] = '{32'hFFFF_FEFE, 32'hFFFF_FFFF, 1'b1};

      // Reset state
      #12;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_data_out", data_out, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Back-to-back sweep of legal then illegal codes
      for (int i = 0; i <= 12; i++) begin
         if (i < 12) begin
            in_valid = 1'b1;
            data_in  = vecs[i].din;
            #1;
            check("stream_in_ready", {31'd0, in_ready}, 32'd1);
         end else begin
            in_valid = 1'b0;
         end
         step();
         if (i == 0) begin
            check("latency_not_yet", {31'd0, out_valid}, 32'd0);
         end else begin
            check("stream_out_valid", {31'd0, out_valid}, 32'd1);
            check("stream_data_out", data_out, vecs[i-1].dout);
            check("stream_err", {31'd0, err}, {31'd0, vecs[i-1].derr});
         end
      end
      step();
      check("drain_out_valid", {31'd0, out_valid}, 32'd0);
      check("drain_data_out", data_out, 32'd0);
      check("drain_err", {31'd0, err}, 32'd0);
      check("illegal_err_cnt", {16'd0, err_cnt}, 32'd4);

      // Backpressure: two words fill the pipe, then the input stalls
      out_ready = 1'b0;
      in_valid  = 1'b1;
      data_in   = 32'hFFFF_FFFB;
      #1;
      check("bp_ready_w0", {31'd0, in_ready}, 32'd1);
      step();
      check("bp_no_out_yet", {31'd0, out_valid}, 32'd0);
      data_in = 32'hFFFF_FFDF;
      #1;
      check("bp_ready_w1", {31'd0, in_ready}, 32'd1);
      step();
      check("bp_out_w0", data_out, 32'd2);
      data_in = 32'hFFFF_FFBF;
      for (int c = 0; c < 4; c++) begin
         check("bp_stalled_ready", {31'd0, in_ready}, 32'd0);
         step();
         check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
         check("bp_hold_data", data_out, 32'd2);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      check("bp_deliver_w1", data_out, 32'd5);
      check("bp_deliver_w1_valid", {31'd0, out_valid}, 32'd1);
      step();
      check("bp_empty_after", {31'd0, out_valid}, 32'd0);

      // Enable low with two words in flight
      out_ready = 1'b0;
      in_valid  = 1'b1;
      data_in   = 32'hFFFF_FFFE;
      step();
      data_in = 32'hFFFF_FF7F;
      step();
      en      = 1'b0;
      data_in = 32'hFFFF_FFFD;
      #1;
      check("en_low_ready", {31'd0, in_ready}, 32'd0);
      check("en_low_out_w0", data_out, 32'd0);
      check("en_low_valid_w0", {31'd0, out_valid}, 32'd1);
      out_ready = 1'b1;
      step();
      check("en_low_out_w1", data_out, 32'd7);
      check("en_low_ready_still", {31'd0, in_ready}, 32'd0);
      step();
      check("en_low_drained", {31'd0, out_valid}, 32'd0);
      en = 1'b1;
      #1;
      check("en_high_ready", {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      step();
      check("en_resume_data", data_out, 32'd1);
      check("en_resume_err", {31'd0, err}, 32'd0);
      step();

      // Counter saturation, then clear coincident with an illegal load
      in_valid = 1'b1;
      data_in  = 32'hFFFF_FFFF;
      repeat (65540) step();
      check("sat_err_cnt", {16'd0, err_cnt}, 32'h0000_FFFF);
      step();
      check("sat_err_cnt_hold", {16'd0, err_cnt}, 32'h0000_FFFF);
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      check("clr_wins", {16'd0, err_cnt}, 32'd0);
      check("clr_out_err", {31'd0, err}, 32'd1);
      in_valid = 1'b0;
      step();
      check("after_clr_inc", {16'd0, err_cnt}, 32'd1);
      step();
      check("after_clr_idle", {16'd0, err_cnt}, 32'd1);

      // Reset pulse between edges with two words in flight
      out_ready = 1'b0;
      in_valid  = 1'b1;
      data_in   = 32'hFFFF_FFF7;
      step();
      data_in = 32'hFFFF_FFEF;
      step();
      in_valid = 1'b0;
      check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
      rst = 1'b0;
      #1;
      check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_err_cnt", {16'd0, err_cnt}, 32'd0);
      check("mid_rst_data", data_out, 32'd0);
      check("mid_rst_ready", {31'd0, in_ready}, 32'd0);
      #1;
      rst       = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         check("no_stale_word", {31'd0, out_valid}, 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
